// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/busy/done conversion handshake and BCD result bundle
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - one-bit-per-clock double-dabble binary-to-BCD converter
// Optional input synchronizer and start edge detector: define BCD_SYNC_EN.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              reset,
    bin_to_bcd_seq_if.slave   bus
);
    localparam int                 ACC_W = 4 * DIGITS;
    localparam int                 CNT_W = $clog2(BIN_W + 1);
    localparam logic [31:0]        MAX_V = 32'(10 ** DIGITS - 1);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(BIN_W - 1);
    localparam logic [ACC_W-1:0]   NINES = {DIGITS{4'h9}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state, state_n;
    logic [BIN_W-1:0]        sh, sh_n;
    logic [ACC_W-1:0]        acc, acc_n, adj;
    logic [ACC_W-1:0]        bcd_q, bcd_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    ovf_flag, ovf_flag_n;
    logic                    ovf_q, ovf_n;
    logic                    done_q, done_n;
    logic [ACC_W+BIN_W-1:0]  cat;
    logic                    go;
    logic [BIN_W-1:0]        bin_use;

`ifdef BCD_SYNC_EN
    logic             s1, s2, s3, pulse;
    logic [BIN_W-1:0] b1, b2;

    // pulse is registered so a held level yields exactly one request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
            b1    <= '0;
            b2    <= '0;
        end else begin
            s1    <= bus.start;
            s2    <= s1;
            s3    <= s2;
            pulse <= s2 & ~s3;
            b1    <= bus.bin_in;
            b2    <= b1;
        end
    end

    assign go      = pulse;
    assign bin_use = b2;
`else
    assign go      = bus.start;
    assign bin_use = bus.bin_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sh       <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            sh       <= sh_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            ovf_flag <= ovf_flag_n;
            bcd_q    <= bcd_n;
            ovf_q    <= ovf_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        sh_n       = sh;
        acc_n      = acc;
        cnt_n      = cnt;
        ovf_flag_n = ovf_flag;
        bcd_n      = bcd_q;
        ovf_n      = ovf_q;
        done_n     = 1'b0;

        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        // bits leaving the top are lost only on overflow, which saturates anyway
        cat = {adj, sh} << 1;

        case (state)
            IDLE: begin
                if (go) begin
                    state_n    = SHIFT;
                    sh_n       = bin_use;
                    acc_n      = '0;
                    cnt_n      = '0;
                    ovf_flag_n = 32'(bin_use) > MAX_V;
                end
            end
            SHIFT: begin
                acc_n = cat[ACC_W+BIN_W-1 -: ACC_W];
                sh_n  = cat[BIN_W-1:0];
                cnt_n = cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    state_n = IDLE;
                    bcd_n   = ovf_flag ? NINES : cat[ACC_W+BIN_W-1 -: ACC_W];
                    ovf_n   = ovf_flag;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - randomized self-checking bench for bin_to_bcd_seq against a decimal model
module tb_bin_to_bcd_seq;
    localparam int BIN_W  = 10;
    localparam int DIGITS = 3;
`ifdef BCD_SYNC_EN
    localparam int LAT = BIN_W + 3;
`else
    localparam int LAT = BIN_W;
`endif

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bif ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // decimal digits by division; values above the digit range saturate to all nines
    function automatic logic [31:0] ref_bcd(input int v);
        logic [31:0] r;
        int          x;
        int          lim;
        r   = 0;
        x   = v;
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        for (int i = 0; i < DIGITS; i++) begin
            if (v >= lim) r = r | (32'd9 << (4 * i));
            else          r = r | (32'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    // starts and ends at a falling edge; holds start across one rising edge
    task automatic launch(input int v);
        bif.start  = 1'b1;
        bif.bin_in = BIN_W'(v);
        @(posedge clk);
        @(negedge clk);
        bif.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int v, input int inj_at, input int inj_v);
        int cyc;
        cyc = 0;
        while (!bif.done && cyc < 60) begin
            if (cyc == inj_at) begin
                bif.start  = 1'b1;
                bif.bin_in = BIN_W'(inj_v);
            end else if (cyc == inj_at + 1) begin
                bif.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, LAT);
        check({tag, "_bcd"}, 32'(bif.bcd_out), ref_bcd(v));
        check({tag, "_ovf"}, 32'(bif.overflow), (v > 999) ? 32'd1 : 32'd0);
        check({tag, "_busy_at_done"}, 32'(bif.busy), 32'd0);
    endtask

    task automatic convert(input string tag, input int v);
        launch(v);
`ifndef BCD_SYNC_EN
        check({tag, "_busy"}, 32'(bif.busy), 32'd1);
        bif.bin_in = BIN_W'($urandom);
`endif
        wait_done(tag, v, -10, 0);
        @(negedge clk);
        check({tag, "_done_clear"}, 32'(bif.done), 32'd0);
        check({tag, "_hold"}, 32'(bif.bcd_out), ref_bcd(v));
    endtask

    initial begin
        int v;
        int dones;
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        bif.start  = 1'b0;
        bif.bin_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_done", 32'(bif.done), 32'd0);
        check("rst_bcd", 32'(bif.bcd_out), 32'd0);
        check("rst_ovf", 32'(bif.overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        convert("zero", 0);
        convert("v255", 255);
        convert("v999", 999);
        convert("v1023", 1023);
        convert("v42", 42);

        // second start while busy must be dropped
        launch(123);
        wait_done("ignored", 123, 6, 456);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bif.done) dones++;
        end
        check("ignored_extra_done", dones, 0);
        check("ignored_hold", 32'(bif.bcd_out), 32'h123);

        // back-to-back: new start raised in the done cycle
        launch(321);
        wait_done("b2b_first", 321, -10, 0);
        launch(7);
`ifndef BCD_SYNC_EN
        check("b2b_no_gap", 32'(bif.busy), 32'd1);
`endif
        wait_done("b2b_second", 7, -10, 0);
        @(negedge clk);

        for (int n = 0; n < 30; n++) begin
            v = int'($urandom_range(0, 1023));
            convert("rand", v);
        end

        // reset mid-conversion clears outputs without a clock and suppresses done
        convert("pre_rst", 1023);
        launch(500);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 32'(bif.busy), 32'd0);
        check("abort_bcd", 32'(bif.bcd_out), 32'd0);
        check("abort_ovf", 32'(bif.overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bif.done) dones++;
        end
        check("abort_no_done", dones, 0);
        convert("post_rst", 77);

`ifdef BCD_SYNC_EN
        begin
            int first;
            dones      = 0;
            first      = -1;
            bif.start  = 1'b1;
            bif.bin_in = BIN_W'(618);
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (i == 20) bif.start = 1'b0;
                if (bif.done) begin
                    dones++;
                    if (first < 0) first = i;
                end
            end
            check("held_one_done", dones, 1);
            check("held_latency", first, LAT);
            check("held_bcd", 32'(bif.bcd_out), ref_bcd(618));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
